// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage payload widths, reset PC and stage-register FSM encoding.
package pipe_pkg;
  localparam int IF_ID_W = 96;
  localparam int ID_EX_W = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 80;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;
  function automatic logic is_occupied(input pipe_state_e st);
    return st != EMPTY;
  endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready/data beat channel between pipeline stages.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master(output valid, output data, input ready);
  modport slave(input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: single-entry holding register with valid flag; clear wins over load.
module pipe_skid_buf #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= !clr && (load || valid);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; define PIPE_SKID_EN for a skid entry and registered s_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = IF_ID_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  pipe_stage_reg_if.slave  s,
  pipe_stage_reg_if.master m
);
  pipe_state_e      state, state_nx;
  logic [WIDTH-1:0] data_q, data_nx;
`ifdef PIPE_SKID_EN
  logic             skid_valid, skid_load, skid_clr;
  logic [WIDTH-1:0] skid_data;
  pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (skid_clr),
    .load (skid_load),
    .d    (s.data),
    .valid(skid_valid),
    .q    (skid_data)
  );
  assign s.ready = !skid_valid;
`else
  assign s.ready = (state == EMPTY) || m.ready;
`endif
  assign m.valid = is_occupied(state);
  assign m.data  = data_q;
  always_comb begin
    state_nx  = state;
    data_nx   = data_q;
`ifdef PIPE_SKID_EN
    skid_load = 1'b0;
    skid_clr  = 1'b0;
`endif
    if (flush) begin
      state_nx = EMPTY;
`ifdef PIPE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: if (s.valid) begin
          state_nx = FULL;
          data_nx  = s.data;
        end
        FULL: if (m.ready) begin
          state_nx = s.valid ? FULL : EMPTY;
          data_nx  = s.valid ? s.data : data_q;
        end
`ifdef PIPE_SKID_EN
        else if (s.valid) begin
          state_nx  = SKID;
          skid_load = 1'b1;
        end
        SKID: if (m.ready) begin
          state_nx = FULL;
          data_nx  = skid_data;
          skid_clr = 1'b1;
        end
`endif
        default: state_nx = EMPTY;
      endcase
    end
  end
  // m_data deliberately keeps its last beat after draining or flushing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      data_q <= RESET_VAL;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized scoreboard bench for pipe_stage_reg.
module tb_pipe_stage_reg;
  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'h0000_1234;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  pipe_stage_reg_if #(.WIDTH(W)) up ();
  pipe_stage_reg_if #(.WIDTH(W)) dn ();
  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .s    (up),
    .m    (dn)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: the stage is a FIFO of at most one (or two with skid) beats
  always @(negedge clk) begin
    int sz;
    if (!rst) q.delete();
    else begin
      sz = q.size();
      if (sz == 0) chk("m_valid_idle", W'(dn.valid), W'(0));
      else begin
        chk("m_valid", W'(dn.valid), W'(1));
        chk("m_data", dn.data, q[0]);
      end
`ifdef PIPE_SKID_EN
      chk("s_ready", W'(up.ready), W'(sz < 2));
`else
      chk("s_ready", W'(up.ready), W'(sz == 0 || dn.ready));
`endif
      if (dn.valid && dn.ready && sz > 0) void'(q.pop_front());
      if (up.valid && up.ready) q.push_back(up.data);
      if (flush) q.delete();
    end
  end
  initial begin
    logic took;
    up.valid = 1'b0;
    up.data = '0;
    dn.ready = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", W'(dn.valid), W'(0));
    chk("rst_m_data", dn.data, RV);
    rst = 1'b1;
    tick();
    chk("post_rst_s_ready", W'(up.ready), W'(1));
    chk("post_rst_m_valid", W'(dn.valid), W'(0));
    chk("post_rst_m_data", dn.data, RV);
    up.valid = 1'b1;
    dn.ready = 1'b1;
    up.data = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("burst_valid", W'(dn.valid), W'(1));
      chk("burst_data", dn.data, W'(i));
      up.data = W'(i + 1);
    end
    up.valid = 1'b0;
    tick();
    dn.ready = 1'b0;
    up.valid = 1'b1;
    up.data = 32'hA;
    tick();
`ifdef PIPE_SKID_EN
    up.data = 32'hB;
    tick();
    chk("skid_s_ready", W'(up.ready), W'(0));
`endif
    up.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", W'(dn.valid), W'(1));
      chk("hold_data", dn.data, 32'hA);
      tick();
    end
    dn.ready = 1'b1;
    tick();
`ifdef PIPE_SKID_EN
    chk("skid_drain_data", dn.data, 32'hB);
    chk("skid_drain_s_ready", W'(up.ready), W'(1));
    tick();
`endif
    chk("drained_valid", W'(dn.valid), W'(0));
    dn.ready = 1'b0;
    up.valid = 1'b1;
    up.data = 32'h9;
    tick();
`ifdef PIPE_SKID_EN
    up.data = 32'h6;
    tick();
`endif
    up.data = 32'h5;
    dn.ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    up.valid = 1'b0;
    chk("flush_valid", W'(dn.valid), W'(0));
    chk("flush_data_held", dn.data, 32'h9);
    repeat (3) tick();
    up.valid = 1'b1;
    up.data = 32'h20;
    tick();
    up.data = 32'h21;
    tick();
    chk("pre_arst_valid", W'(dn.valid), W'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", W'(dn.valid), W'(0));
    chk("arst_data", dn.data, RV);
    up.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("arst_rel_s_ready", W'(up.ready), W'(1));
    up.valid = 1'b1;
    up.data = 32'h7;
    tick();
    chk("arst_first_valid", W'(dn.valid), W'(1));
    chk("arst_first_data", dn.data, 32'h7);
    up.valid = 1'b0;
    tick();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      took = (up.valid && up.ready) || flush;
      @(posedge clk);
      #1;
      if (!up.valid || took) begin
        up.valid = ($urandom_range(0, 3) != 0);
        up.data = $urandom;
      end
      dn.ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
    end
    flush = 1'b0;
    up.valid = 1'b0;
    dn.ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", W'(q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
